// File: rtl/servo_pulse_decoder_if.sv
// servo_pulse_decoder_if
//   Groups the pulse-decoder signals so that a producer/consumer and the
//   decoder share one bundle. clk and rst_n stay plain module ports.
//
//   Signals:
//     ena        clock enable; all decoder state holds while low
//     pwm_in     asynchronous servo pulse input
//     position   last accepted position (0 = 1.0 ms, 255 ~ 2.0 ms)
//     pos_valid  one-cycle strobe: position was just updated
//     pos_err    one-cycle strobe: a pulse was rejected (glitch or overlong)
//     link_ok    high while accepted pulses keep arriving within the timeout
//     dbg_state  current decoder FSM state, for observation only
//
//   Handshake: there is no back-pressure. pos_valid and pos_err are
//   fire-and-forget strobes that are high for exactly one clock and are
//   never high together; position is stable and already updated in the
//   pos_valid cycle and holds until the next pos_valid. The consumer must
//   sample on every cycle in which a strobe is high.
//
//   Modports:
//     slave   the decoder (drives the results)
//     master  the side that drives ena/pwm_in and consumes the results
interface servo_pulse_decoder_if;
    logic       ena;
    logic       pwm_in;
    logic [7:0] position;
    logic       pos_valid;
    logic       pos_err;
    logic       link_ok;
    logic [1:0] dbg_state;

    modport slave (
        input  ena,
        input  pwm_in,
        output position,
        output pos_valid,
        output pos_err,
        output link_ok,
        output dbg_state
    );

    modport master (
        output ena,
        output pwm_in,
        input  position,
        input  pos_valid,
        input  pos_err,
        input  link_ok,
        input  dbg_state
    );
endinterface

// File: rtl/servo_pulse_decoder.sv
// servo_pulse_decoder
//   Measures the high time of an RC-servo PWM pulse in clock cycles and
//   converts it to an 8-bit position: position 0 at MIN_WIDTH cycles, one
//   LSB per STEP cycles above that, saturating at 255. Pulses shorter than
//   MIN_ACCEPT or reaching MAX_WIDTH are rejected with pos_err. link_ok
//   drops after FRAME_TIMEOUT cycles without an accepted pulse.
//
//   Ports:
//     clk    clock (10 MHz nominal)
//     rst_n  asynchronous active-low reset
//     bus    servo_pulse_decoder_if.slave (ena, pwm_in in; position,
//            pos_valid, pos_err, link_ok, dbg_state out)
module servo_pulse_decoder #(
    parameter int unsigned MIN_WIDTH     = 10000,
    parameter int unsigned STEP          = 39,
    parameter int unsigned MIN_ACCEPT    = 5000,
    parameter int unsigned MAX_WIDTH     = 25000,
    parameter int unsigned FRAME_TIMEOUT = 250000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    servo_pulse_decoder_if.slave bus
);
    localparam logic [17:0] MIN_W   = 18'(MIN_WIDTH);
    localparam logic [17:0] STEP_M1 = 18'(STEP - 1);
    localparam logic [17:0] ACC_W   = 18'(MIN_ACCEPT);
    localparam logic [17:0] MAX_W   = 18'(MAX_WIDTH);
    localparam logic [17:0] TMO_W   = 18'(FRAME_TIMEOUT);

    typedef enum logic [1:0] {
        ST_ARM      = 2'd0,
        ST_IDLE     = 2'd1,
        ST_HIGH     = 2'd2,
        ST_OVERLONG = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        s_meta_q, s_q, s_d_q;
    logic [1:0]  arm_cnt_q, arm_cnt_d;
    logic [17:0] width_q, width_d;
    logic [17:0] pre_q, pre_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  position_q, position_d;
    logic        pos_valid_q, pos_valid_d;
    logic        pos_err_q, pos_err_d;
    logic [17:0] tmo_q, tmo_d;
    logic        link_q, link_d;

    logic        rise, fall, clear;
    logic [17:0] base_w, base_p, w_inc, p_inc;
    logic [7:0]  base_a, a_inc;

    // Synchronizer plus one delay flop for edge detection; frozen with ena
    // so edges that happen while disabled are never observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta_q <= 1'b0;
            s_q      <= 1'b0;
            s_d_q    <= 1'b0;
        end else if (bus.ena) begin
            s_meta_q <= bus.pwm_in;
            s_q      <= s_meta_q;
            s_d_q    <= s_q;
        end
    end

    assign rise = s_q & ~s_d_q;
    assign fall = ~s_q & s_d_q;

    // One counting step for an edge at which s = 1. The rise edge itself
    // counts, so on a rise the step starts from cleared counters.
    // Division-free mapping: once the width exceeds MIN_WIDTH, every STEP
    // further cycles add one to a saturating accumulator.
    always_comb begin
        clear  = (state_q == ST_IDLE) && rise;
        base_w = clear ? 18'd0 : width_q;
        base_p = clear ? 18'd0 : pre_q;
        base_a = clear ? 8'd0  : acc_q;
        w_inc  = (base_w >= MAX_W) ? MAX_W : base_w + 18'd1;
        p_inc  = base_p;
        a_inc  = base_a;
        if (w_inc > MIN_W) begin
            if (base_p >= STEP_M1) begin
                p_inc = 18'd0;
                if (base_a != 8'hFF) begin
                    a_inc = base_a + 8'd1;
                end
            end else begin
                p_inc = base_p + 18'd1;
            end
        end
    end

    // Decoder FSM. ARM first lets the synchronizer fill with real samples
    // (three enabled edges) so that the reset zeros are not mistaken for a
    // low input; it then waits for the input to be low.
    always_comb begin
        state_d     = state_q;
        arm_cnt_d   = arm_cnt_q;
        width_d     = width_q;
        pre_d       = pre_q;
        acc_d       = acc_q;
        position_d  = position_q;
        pos_valid_d = 1'b0;
        pos_err_d   = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (arm_cnt_q != 2'd3) begin
                    arm_cnt_d = arm_cnt_q + 2'd1;
                end else if (!s_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_HIGH;
                    width_d = w_inc;
                    pre_d   = p_inc;
                    acc_d   = a_inc;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (width_q < ACC_W) begin
                        pos_err_d = 1'b1;
                    end else begin
                        position_d  = acc_q;
                        pos_valid_d = 1'b1;
                    end
                end else begin
                    width_d = w_inc;
                    pre_d   = p_inc;
                    acc_d   = a_inc;
                    if (w_inc == MAX_W) begin
                        pos_err_d = 1'b1;
                        state_d   = ST_OVERLONG;
                    end
                end
            end
            ST_OVERLONG: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    // Link monitor: only accepted pulses restart the timeout.
    always_comb begin
        tmo_d  = tmo_q;
        link_d = link_q;
        if (pos_valid_d) begin
            tmo_d  = 18'd0;
            link_d = 1'b1;
        end else if (tmo_q != TMO_W) begin
            tmo_d = tmo_q + 18'd1;
            if (tmo_d == TMO_W) begin
                link_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ARM;
            arm_cnt_q   <= 2'd0;
            width_q     <= 18'd0;
            pre_q       <= 18'd0;
            acc_q       <= 8'd0;
            position_q  <= 8'd0;
            pos_valid_q <= 1'b0;
            pos_err_q   <= 1'b0;
            tmo_q       <= 18'd0;
            link_q      <= 1'b0;
        end else begin
            // Strobes are not held across a disabled edge, so they cannot
            // reappear when ena returns.
            pos_valid_q <= bus.ena & pos_valid_d;
            pos_err_q   <= bus.ena & pos_err_d;
            if (bus.ena) begin
                state_q    <= state_d;
                arm_cnt_q  <= arm_cnt_d;
                width_q    <= width_d;
                pre_q      <= pre_d;
                acc_q      <= acc_d;
                position_q <= position_d;
                tmo_q      <= tmo_d;
                link_q     <= link_d;
            end
        end
    end

    assign bus.position  = position_q;
    assign bus.pos_valid = pos_valid_q & bus.ena;
    assign bus.pos_err   = pos_err_q & bus.ena;
    assign bus.link_ok   = link_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_servo_pulse_decoder.sv
// tb_servo_pulse_decoder
//   Self-checking bench for servo_pulse_decoder with scaled-down timing
//   parameters so every scenario fits in a short run. Expected positions,
//   strobe kinds and strobe cycles come from a pulse-level reference model
//   (position formula and accept/reject rules on the pulse length).
module tb_servo_pulse_decoder;
    localparam int MIN_WIDTH     = 300;
    localparam int STEP          = 3;
    localparam int MIN_ACCEPT    = 150;
    localparam int MAX_WIDTH     = 1200;
    localparam int FRAME_TIMEOUT = 4000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    servo_pulse_decoder_if bus();

    servo_pulse_decoder #(
        .MIN_WIDTH     (MIN_WIDTH),
        .STEP          (STEP),
        .MIN_ACCEPT    (MIN_ACCEPT),
        .MAX_WIDTH     (MAX_WIDTH),
        .FRAME_TIMEOUT (FRAME_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard / monitor ----------------
    logic [7:0] vpos_q[$];
    int         vcyc_q[$];
    int         ecyc_q[$];
    logic [7:0] exp_q[$];
    int         both_cnt = 0;
    int         gated_bad = 0;
    int         drop_cyc = -1;
    logic       link_prev = 1'b0;
    logic [7:0] model_position = 8'd0;

    always @(negedge clk) begin
        if (bus.pos_valid === 1'b1) begin
            vpos_q.push_back(bus.position);
            vcyc_q.push_back(cyc);
        end
        if (bus.pos_err === 1'b1) ecyc_q.push_back(cyc);
        if (bus.pos_valid === 1'b1 && bus.pos_err === 1'b1) both_cnt++;
        if (bus.ena === 1'b0 && (bus.pos_valid !== 1'b0 || bus.pos_err !== 1'b0)) gated_bad++;
        if (link_prev === 1'b1 && bus.link_ok === 1'b0) drop_cyc = cyc;
        link_prev = bus.link_ok;
    end

    // ---------------- reference model ----------------
    function automatic int model_pos(input int w);
        int p;
        if (w < MIN_WIDTH) return 0;
        p = (w - MIN_WIDTH) / STEP;
        return (p > 255) ? 255 : p;
    endfunction

    // 0 = glitch, 1 = accepted, 2 = overlong
    function automatic int model_kind(input int w);
        if (w < MIN_ACCEPT) return 0;
        if (w >= MAX_WIDTH) return 2;
        return 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        vpos_q.delete();
        vcyc_q.delete();
        ecyc_q.delete();
    endtask

    // pwm_in high for w enabled samples; r/f are the cycles of the drive.
    task automatic drive_pulse(input int w, input int gap, output int r, output int f);
        r = cyc;
        bus.pwm_in = 1'b1;
        tick(w);
        f = cyc;
        bus.pwm_in = 1'b0;
        tick(gap);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int r, f;
        bus.ena = 1'b1;
        bus.pwm_in = 1'b1;
        rst_n = 1'b0;
        tick(5);
        checks++;
        if ({bus.position, bus.pos_valid, bus.pos_err, bus.link_ok} !== 11'd0) begin
            errors++;
            $display("FAIL reset_values: got %0h expected 0", {bus.position, bus.pos_valid, bus.pos_err, bus.link_ok});
        end
        clear_mon();
        rst_n = 1'b1;
        tick(60);
        checks++;
        if (vpos_q.size() != 0 || ecyc_q.size() != 0 || bus.position !== 8'd0 || bus.link_ok !== 1'b0) begin
            errors++;
            $display("FAIL arm_high_input: got %0d strobes pos %0d link %0b expected none/0/0",
                     vpos_q.size() + ecyc_q.size(), bus.position, bus.link_ok);
        end
        bus.pwm_in = 1'b0;
        tick(10);
        clear_mon();
        drive_pulse(684, 10, r, f);
        checks++;
        if (vpos_q.size() != 1 || ecyc_q.size() != 0) begin
            errors++;
            $display("FAIL first_pulse_count: got %0d valid %0d err expected 1/0", vpos_q.size(), ecyc_q.size());
        end else begin
            checks++;
            if (vpos_q[0] !== 8'd128) begin
                errors++;
                $display("FAIL first_pulse_pos: got %0d expected 128", vpos_q[0]);
            end
        end
        checks++;
        if (bus.link_ok !== 1'b1) begin
            errors++;
            $display("FAIL first_pulse_link: got %0b expected 1", bus.link_ok);
        end
        model_position = 8'd128;
    endtask

    task automatic test_mapping();
        int widths[6] = '{300, 302, 303, 1064, 1065, 1199};
        int exps[6]   = '{0, 0, 1, 254, 255, 255};
        int r, f;
        for (int i = 0; i < 6; i++) begin
            clear_mon();
            drive_pulse(widths[i], 10, r, f);
            checks++;
            if (vpos_q.size() != 1 || ecyc_q.size() != 0) begin
                errors++;
                $display("FAIL map_count w=%0d: got %0d valid %0d err expected 1/0", widths[i], vpos_q.size(), ecyc_q.size());
            end else begin
                checks++;
                if (vpos_q[0] !== 8'(exps[i])) begin
                    errors++;
                    $display("FAIL map_pos w=%0d: got %0d expected %0d", widths[i], vpos_q[0], exps[i]);
                end
                checks++;
                if (vcyc_q[0] != f + 3) begin
                    errors++;
                    $display("FAIL map_latency w=%0d: got cycle %0d expected %0d", widths[i], vcyc_q[0], f + 3);
                end
            end
            model_position = 8'(exps[i]);
        end
    endtask

    task automatic test_glitch();
        int widths[3] = '{20, 149, 150};
        int r, f;
        drive_pulse(684, 10, r, f);
        model_position = 8'd128;
        for (int i = 0; i < 3; i++) begin
            clear_mon();
            drive_pulse(widths[i], 10, r, f);
            if (model_kind(widths[i]) == 0) begin
                checks++;
                if (ecyc_q.size() != 1 || vpos_q.size() != 0) begin
                    errors++;
                    $display("FAIL glitch_count w=%0d: got %0d err %0d valid expected 1/0", widths[i], ecyc_q.size(), vpos_q.size());
                end else begin
                    checks++;
                    if (ecyc_q[0] != f + 3) begin
                        errors++;
                        $display("FAIL glitch_latency w=%0d: got cycle %0d expected %0d", widths[i], ecyc_q[0], f + 3);
                    end
                end
                checks++;
                if (bus.position !== model_position) begin
                    errors++;
                    $display("FAIL glitch_hold w=%0d: got %0d expected %0d", widths[i], bus.position, model_position);
                end
            end else begin
                checks++;
                if (vpos_q.size() != 1 || ecyc_q.size() != 0 || bus.position !== 8'(model_pos(widths[i]))) begin
                    errors++;
                    $display("FAIL min_accept w=%0d: got %0d valid pos %0d expected 1 valid pos %0d",
                             widths[i], vpos_q.size(), bus.position, model_pos(widths[i]));
                end
                model_position = 8'(model_pos(widths[i]));
            end
        end
    endtask

    task automatic test_overlong();
        int r, f;
        clear_mon();
        drive_pulse(1500, 10, r, f);
        checks++;
        if (ecyc_q.size() != 1 || vpos_q.size() != 0) begin
            errors++;
            $display("FAIL overlong_count: got %0d err %0d valid expected 1/0", ecyc_q.size(), vpos_q.size());
        end else begin
            checks++;
            if (ecyc_q[0] != r + 2 + MAX_WIDTH) begin
                errors++;
                $display("FAIL overlong_time: got cycle %0d expected %0d", ecyc_q[0], r + 2 + MAX_WIDTH);
            end
        end
        checks++;
        if (bus.position !== model_position) begin
            errors++;
            $display("FAIL overlong_hold: got %0d expected %0d", bus.position, model_position);
        end
        clear_mon();
        drive_pulse(684, 10, r, f);
        checks++;
        if (vpos_q.size() != 1 || ecyc_q.size() != 0 || bus.position !== 8'd128) begin
            errors++;
            $display("FAIL after_overlong: got %0d valid pos %0d expected 1 valid pos 128", vpos_q.size(), bus.position);
        end
        model_position = 8'd128;
    endtask

    task automatic test_timeout();
        int r, f, e, n, budget;
        clear_mon();
        drive_pulse(684, 10, r, f);
        e = (vcyc_q.size() > 0) ? vcyc_q[0] : f + 3;
        drop_cyc = -1;
        budget = 0;
        while (drop_cyc < 0 && budget < FRAME_TIMEOUT + 200) begin
            tick(1);
            budget++;
        end
        checks++;
        if (drop_cyc != e + FRAME_TIMEOUT) begin
            errors++;
            $display("FAIL timeout_drop: got cycle %0d expected %0d", drop_cyc, e + FRAME_TIMEOUT);
        end
        clear_mon();
        drive_pulse(684, 10, r, f);
        checks++;
        if (bus.link_ok !== 1'b1 || vcyc_q.size() != 1) begin
            errors++;
            $display("FAIL link_restore: got link %0b valid %0d expected 1/1", bus.link_ok, vcyc_q.size());
        end
        e = (vcyc_q.size() > 0) ? vcyc_q[0] : f + 3;
        clear_mon();
        drop_cyc = -1;
        n = 0;
        while (drop_cyc < 0 && n < 60) begin
            drive_pulse(20, 150, r, f);
            n++;
        end
        checks++;
        if (drop_cyc != e + FRAME_TIMEOUT) begin
            errors++;
            $display("FAIL glitch_stream_drop: got cycle %0d expected %0d", drop_cyc, e + FRAME_TIMEOUT);
        end
        checks++;
        if (ecyc_q.size() != n || vpos_q.size() != 0) begin
            errors++;
            $display("FAIL glitch_stream_count: got %0d err %0d valid expected %0d/0", ecyc_q.size(), vpos_q.size(), n);
        end
    endtask

    task automatic test_enable();
        int r, f;
        clear_mon();
        bus.pwm_in = 1'b1;
        tick(350);
        bus.ena = 1'b0;
        tick(200);
        bus.ena = 1'b1;
        tick(350);
        f = cyc;
        bus.pwm_in = 1'b0;
        tick(10);
        checks++;
        if (vpos_q.size() != 1 || ecyc_q.size() != 0) begin
            errors++;
            $display("FAIL ena_freeze_count: got %0d valid %0d err expected 1/0", vpos_q.size(), ecyc_q.size());
        end else begin
            checks++;
            if (vpos_q[0] !== 8'(model_pos(900 - 200)) || vcyc_q[0] != f + 3) begin
                errors++;
                $display("FAIL ena_freeze_pos: got %0d at %0d expected %0d at %0d",
                         vpos_q[0], vcyc_q[0], model_pos(700), f + 3);
            end
        end
        model_position = 8'(model_pos(700));
        clear_mon();
        bus.ena = 1'b0;
        tick(5);
        drive_pulse(300, 5, r, f);
        bus.ena = 1'b1;
        tick(20);
        checks++;
        if (vpos_q.size() != 0 || ecyc_q.size() != 0 || bus.position !== model_position) begin
            errors++;
            $display("FAIL ena_hidden_pulse: got %0d strobes pos %0d expected 0 strobes pos %0d",
                     vpos_q.size() + ecyc_q.size(), bus.position, model_position);
        end
    endtask

    task automatic test_random();
        int w, g, r, f, k, exp_c;
        for (int i = 0; i < 12; i++) begin
            w = $urandom_range(1, MAX_WIDTH + 200);
            g = $urandom_range(10, 40);
            k = model_kind(w);
            clear_mon();
            drive_pulse(w, g, r, f);
            if (k == 1) begin
                exp_q.push_back(8'(model_pos(w)));
                checks++;
                if (vpos_q.size() != 1 || ecyc_q.size() != 0) begin
                    errors++;
                    $display("FAIL rand_accept_count w=%0d: got %0d valid %0d err expected 1/0", w, vpos_q.size(), ecyc_q.size());
                    void'(exp_q.pop_front());
                end else begin
                    checks++;
                    if (vpos_q[0] !== exp_q[0] || vcyc_q[0] != f + 3) begin
                        errors++;
                        $display("FAIL rand_accept w=%0d: got %0d at %0d expected %0d at %0d", w, vpos_q[0], vcyc_q[0], exp_q[0], f + 3);
                    end
                    model_position = exp_q.pop_front();
                end
            end else begin
                exp_c = (k == 0) ? f + 3 : r + 2 + MAX_WIDTH;
                checks++;
                if (ecyc_q.size() != 1 || vpos_q.size() != 0) begin
                    errors++;
                    $display("FAIL rand_reject_count w=%0d: got %0d err %0d valid expected 1/0", w, ecyc_q.size(), vpos_q.size());
                end else begin
                    checks++;
                    if (ecyc_q[0] != exp_c) begin
                        errors++;
                        $display("FAIL rand_reject_time w=%0d: got cycle %0d expected %0d", w, ecyc_q[0], exp_c);
                    end
                end
                checks++;
                if (bus.position !== model_position) begin
                    errors++;
                    $display("FAIL rand_reject_hold w=%0d: got %0d expected %0d", w, bus.position, model_position);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.ena = 1'b1;
        bus.pwm_in = 1'b0;
        test_reset();
        test_mapping();
        test_glitch();
        test_overlong();
        test_timeout();
        test_enable();
        test_random();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL strobe_exclusive: got %0d overlapping cycles expected 0", both_cnt);
        end
        checks++;
        if (gated_bad != 0) begin
            errors++;
            $display("FAIL strobe_gating: got %0d strobes while disabled expected 0", gated_bad);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
